// File: rtl/stream_fifo_pkt_if.sv
// AXI-stream style channel: data, end-of-packet sideband and valid/ready handshake.
interface stream_fifo_pkt_if #(
    parameter int unsigned DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/stream_fifo_pkt.sv
// Buffered stream FIFO with tlast sideband, fill-level status and optional
// store-and-forward packet mode with early release for oversize packets.
module stream_fifo_pkt #(
    parameter int unsigned DATA_WIDTH         = 512,
    parameter int unsigned DEPTH              = 16,
    parameter int unsigned PACKET_MODE        = 0,
    parameter int unsigned ALMOST_FULL_MARGIN = 2
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    stream_fifo_pkt_if.slave       s,
    stream_fifo_pkt_if.master      m,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] pkt_count,
    output logic                   almost_full,
    output logic                   oversize
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - ALMOST_FULL_MARGIN);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                areset_q;
    logic                rel;

    logic                push_c;
    logic                pop_c;
    logic                rel_set_c;
    logic                rel_clr_c;
    logic [CW-1:0]       count_nxt_c;
    logic [CW-1:0]       pkt_nxt_c;

    // Ready ignores the read side: no push is taken while full, even alongside a pop.
    assign s.tready = !areset_q && (count != FULL_LVL);
    assign push_c   = s.tvalid && s.tready;

    // First-word fall-through read port.
    assign {m.tlast, m.tdata} = mem[rd_ptr];
    assign m.tvalid = (PACKET_MODE != 0) ? ((pkt_count != '0) || rel)
                                         : (count != '0);
    assign pop_c    = m.tvalid && m.tready;

    always_comb begin
        count_nxt_c = count;
        pkt_nxt_c   = pkt_count;
        rel_set_c   = 1'b0;
        rel_clr_c   = 1'b0;
        unique case ({push_c, pop_c})
            2'b10:   count_nxt_c = count + CW'(1);
            2'b01:   count_nxt_c = count - CW'(1);
            default: count_nxt_c = count;
        endcase
        unique case ({push_c && s.tlast, pop_c && m.tlast})
            2'b10:   pkt_nxt_c = pkt_count + CW'(1);
            2'b01:   pkt_nxt_c = pkt_count - CW'(1);
            default: pkt_nxt_c = pkt_count;
        endcase
        // A buffer full of one unterminated packet would otherwise never drain.
        if ((PACKET_MODE != 0) && !rel && (count == FULL_LVL) && (pkt_count == '0)) begin
            rel_set_c = 1'b1;
        end
        if (pop_c && m.tlast) begin
            rel_clr_c = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_c) begin
            mem[wr_ptr] <= {s.tlast, s.tdata};
        end
    end

    always_ff @(posedge ACLK) begin
        areset_q <= ARESET;
        if (ARESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pkt_count   <= '0;
            rel         <= 1'b0;
            almost_full <= 1'b0;
            oversize    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count       <= count_nxt_c;
            pkt_count   <= pkt_nxt_c;
            almost_full <= (count_nxt_c >= AF_LVL);
            oversize    <= rel_set_c;
            if (rel_set_c) begin
                rel <= 1'b1;
            end else if (rel_clr_c) begin
                rel <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_fifo_pkt.sv
// Scoreboard bench for stream_fifo_pkt: one cut-through and one packet-mode instance,
// stimulus routed to the selected one, checked against a queue-based reference model.
module tb_stream_fifo_pkt;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          areset    = 1'b1;
    logic          sel       = 1'b0;
    logic          drv_valid = 1'b0;
    logic [DW-1:0] drv_data  = '0;
    logic          drv_last  = 1'b0;
    logic          rdy       = 1'b0;
    bit            rand_rdy  = 1'b0;

    stream_fifo_pkt_if #(.DATA_WIDTH(DW)) s0 ();
    stream_fifo_pkt_if #(.DATA_WIDTH(DW)) m0 ();
    stream_fifo_pkt_if #(.DATA_WIDTH(DW)) s1 ();
    stream_fifo_pkt_if #(.DATA_WIDTH(DW)) m1 ();

    logic [CW-1:0] cnt0, cnt1, pc0, pc1;
    logic          af0, af1, ov0, ov1;

    assign s0.tvalid = !sel && drv_valid;
    assign s0.tdata  = drv_data;
    assign s0.tlast  = drv_last;
    assign m0.tready = !sel && rdy;
    assign s1.tvalid = sel && drv_valid;
    assign s1.tdata  = drv_data;
    assign s1.tlast  = drv_last;
    assign m1.tready = sel && rdy;

    stream_fifo_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0), .ALMOST_FULL_MARGIN(2)) u0 (
        .ACLK(clk), .ARESET(areset), .s(s0), .m(m0),
        .count(cnt0), .pkt_count(pc0), .almost_full(af0), .oversize(ov0));

    stream_fifo_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1), .ALMOST_FULL_MARGIN(2)) u1 (
        .ACLK(clk), .ARESET(areset), .s(s1), .m(m1),
        .count(cnt1), .pkt_count(pc1), .almost_full(af1), .oversize(ov1));

    wire          mon_sready = sel ? s1.tready : s0.tready;
    wire          mon_mvalid = sel ? m1.tvalid : m0.tvalid;
    wire [DW-1:0] mon_mdata  = sel ? m1.tdata  : m0.tdata;
    wire          mon_mlast  = sel ? m1.tlast  : m0.tlast;
    wire [CW-1:0] mon_cnt    = sel ? cnt1 : cnt0;
    wire [CW-1:0] mon_pc     = sel ? pc1  : pc0;
    wire          mon_af     = sel ? af1  : af0;
    wire          mon_ov     = sel ? ov1  : ov0;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    // Reference model: beats accepted but not yet delivered, plus early-release state.
    beat_t exp_q[$];
    bit    chk_en   = 1'b0;
    bit    prev_rst = 1'b1;
    bit    m_rel    = 1'b0;
    bit    m_ovs    = 1'b0;
    int    n_checks = 0;
    int    n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic int q_lasts();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].last) n++;
        return n;
    endfunction

    int    mon_sz;
    int    mon_nl;
    bit    mon_mv;
    beat_t mon_b;

    // Monitor: compare status against the model, then apply this cycle's pop.
    always @(negedge clk) begin
        if (chk_en) begin
            mon_sz = exp_q.size();
            mon_nl = q_lasts();
            mon_mv = sel ? ((mon_nl != 0) || m_rel) : (mon_sz != 0);
            check("s_tready",    64'(mon_sready), 64'(!prev_rst && (mon_sz != DEPTH)));
            check("m_tvalid",    64'(mon_mvalid), 64'(mon_mv));
            check("count",       64'(mon_cnt),    64'(mon_sz));
            check("pkt_count",   64'(mon_pc),     64'(mon_nl));
            check("almost_full", 64'(mon_af),     64'(mon_sz >= DEPTH - 2));
            check("oversize",    64'(mon_ov),     64'(m_ovs));
            m_ovs = 1'b0;
            if (sel && !m_rel && (mon_sz == DEPTH) && (mon_nl == 0)) begin
                m_rel = 1'b1;
                m_ovs = 1'b1;
            end
            if (mon_mvalid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("pop_empty", 64'(1), 64'(0));
                end else begin
                    mon_b = exp_q.pop_front();
                    check("m_tdata", 64'(mon_mdata), 64'(mon_b.data));
                    check("m_tlast", 64'(mon_mlast), 64'(mon_b.last));
                    if (mon_b.last) m_rel = 1'b0;
                end
            end
            if (areset) begin
                exp_q.delete();
                m_rel = 1'b0;
                m_ovs = 1'b0;
            end
            prev_rst = areset;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one beat; the model records it on the edge where it is accepted.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int budget = 0;
        bit ok = 1'b0;
        drv_valid = 1'b1;
        drv_data  = d;
        drv_last  = l;
        while (!ok && budget < 500) begin
            @(negedge clk);
            budget++;
            if (mon_sready) ok = 1'b1;
            @(posedge clk);
            if (ok) exp_q.push_back(beat_t'({l, d}));
            #1;
        end
        drv_valid = 1'b0;
        if (!ok) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            idle(1);
            budget++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
        idle(2);
    endtask

    task automatic do_reset();
        rdy       = 1'b0;
        drv_valid = 1'b0;
        areset    = 1'b1;
        idle(1);
        areset = 1'b0;
        idle(2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        areset = 1'b0;
        idle(2);

        // Cut-through: fill to full, then a full-cycle with push attempt and pop.
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(DW'(i), i == 7);
        idle(2);
        rdy = 1'b1;
        fork
            begin
                @(posedge clk);
                #1;
                rdy = 1'b0;
            end
        join_none
        send(DW'(100), 1'b1);
        idle(1);
        rdy = 1'b1;
        wait_drain();

        // Back-to-back streaming across several pointer wraps.
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) send(DW'(200 + i), i == 19);
        wait_drain();

        // Randomised cut-through traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(DW'($urandom), $urandom_range(0, 4) == 0);
        end
        rand_rdy = 1'b0;
        rdy = 1'b1;
        wait_drain();

        // Store-and-forward instance.
        sel = 1'b1;
        do_reset();

        rdy = 1'b1;
        send(DW'(300), 1'b0);
        send(DW'(301), 1'b0);
        idle(3);
        send(DW'(302), 1'b1);
        wait_drain();

        // Oversize packet forces early release; the following packet is held again.
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(DW'(400 + i), 1'b0);
        idle(3);
        rdy = 1'b1;
        for (int i = 8; i < 12; i++) send(DW'(400 + i), i == 11);
        send(DW'(500), 1'b0);
        idle(3);
        send(DW'(501), 1'b1);
        wait_drain();

        // Randomised packets of 1..12 beats with random backpressure.
        rand_rdy = 1'b1;
        for (int p = 0; p < 25; p++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 4) == 0) idle(1);
                send(DW'($urandom), b == len - 1);
            end
        end
        rand_rdy = 1'b0;
        rdy = 1'b1;
        wait_drain();

        // Reset with a partial packet stored; none of it may reappear.
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(DW'(600 + i), 1'b0);
        idle(1);
        do_reset();
        rdy = 1'b1;
        send(DW'(700), 1'b0);
        send(DW'(701), 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
